x86_stream_length_decoder: RTL and testbench

- Byte-serial IA-32 (32-bit mode) instruction-boundary decoder.
- Accepts 32-bit little-endian instruction words from the instruction memory path and walks prefixes, opcode, ModRM, SIB, displacement and immediate bytes.
- Reports the operand-size class of each completed instruction on o_instr_size.
- Sits between the instruction fetch/memory port and the downstream execute front-end.

---
 rtl/x86_stream_length_decoder_if.sv | 19 +
 rtl/x86_stream_length_decoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 tb/tb_x86_stream_length_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x86_stream_length_decoder_if.sv
// Instruction-word intake bus between the fetch/memory port and the
// length decoder. The fetch side is the master; the decoder is the slave.
interface x86_stream_length_decoder_if;
    logic        i_ready;
    logic [31:0] i_data;
    logic [1:0]  o_instr_size;

    modport master (
        output i_ready,
        output i_data,
        input  o_instr_size
    );

    modport slave (
        input  i_ready,
        input  i_data,
        output o_instr_size
    );
endinterface

// File: rtl/x86_stream_length_decoder.sv
// Byte-serial IA-32 (32-bit mode) instruction boundary decoder.
// A 32-bit word is latched into a one-word buffer, then its four byte lanes
// are walked one per cycle through prefix / opcode / ModRM / SIB /
// displacement / immediate states. When an instruction's last byte is
// consumed, its operand-size class is registered onto o_instr_size.
module x86_stream_length_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    x86_stream_length_decoder_if.slave   bus
);

    // Operand-size classes reported downstream
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;
    localparam logic [1:0] SZ_NONE  = 2'b11;

    // Immediate kinds attached to a primary opcode
    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_8    = 2'd1;
    localparam logic [1:0] IMM_Z    = 2'd2;
    localparam logic [1:0] IMM_16   = 2'd3;

    typedef enum logic [2:0] {
        ST_PREFIX  = 3'd0,
        ST_OPCODE2 = 3'd1,
        ST_MODRM   = 3'd2,
        ST_SIB     = 3'd3,
        ST_DISP    = 3'd4,
        ST_IMM     = 3'd5
    } state_e;

    typedef struct packed {
        logic       defined;
        logic       modrm;
        logic [1:0] imm;
        logic       imm_reg0;   // immediate present only when ModRM.reg == 000
    } op_info_t;

    // Legacy prefixes accepted in front of an opcode
    function automatic logic is_prefix_byte(input logic [7:0] b);
        return b inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
                         8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    endfunction

    // Opcodes whose operand is a single byte (AL / r8 / m8 forms)
    function automatic logic is_byte_op(input logic [7:0] op);
        logic alu_byte;
        alu_byte = (op[7:6] == 2'b00) &&
                   ((op[2:0] == 3'd0) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4));
        return alu_byte ||
               (op inside {8'h80, 8'h84, 8'h86, 8'h88, 8'h8A, [8'hB0:8'hB7],
                           8'hC0, 8'hC6, 8'hD0, 8'hD2, 8'hF6, 8'hFE});
    endfunction

    // Primary opcode map: which trailing fields follow the opcode byte
    function automatic op_info_t classify_op(input logic [7:0] op);
        op_info_t info;
        info.defined  = 1'b1;
        info.modrm    = 1'b0;
        info.imm      = IMM_NONE;
        info.imm_reg0 = 1'b0;
        if (op[7:6] == 2'b00) begin
            case (op[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: info.modrm = 1'b1;
                3'd4:                   info.imm   = IMM_8;
                3'd5:                   info.imm   = IMM_Z;
                default:                info.modrm = 1'b0;  // segment push/pop, BCD adjust
            endcase
        end else if (op inside {[8'h40:8'h5F], [8'h90:8'h9F], 8'hC3, 8'hC9, 8'hCC, 8'hF4}) begin
            info.imm = IMM_NONE;
        end else if (op inside {8'h68, [8'hB8:8'hBF], 8'hE8, 8'hE9}) begin
            info.imm = IMM_Z;
        end else if (op inside {8'h6A, [8'h70:8'h7F], [8'hB0:8'hB7], 8'hEB}) begin
            info.imm = IMM_8;
        end else if (op == 8'hC2) begin
            info.imm = IMM_16;
        end else if (op inside {8'h69, 8'h81, 8'hC7}) begin
            info.modrm = 1'b1;
            info.imm   = IMM_Z;
        end else if (op inside {8'h6B, 8'h80, 8'h83, 8'hC0, 8'hC1, 8'hC6}) begin
            info.modrm = 1'b1;
            info.imm   = IMM_8;
        end else if (op inside {[8'h84:8'h8F], [8'hD0:8'hD3], 8'hFE, 8'hFF}) begin
            info.modrm = 1'b1;
        end else if (op == 8'hF6) begin
            info.modrm    = 1'b1;
            info.imm      = IMM_8;
            info.imm_reg0 = 1'b1;
        end else if (op == 8'hF7) begin
            info.modrm    = 1'b1;
            info.imm      = IMM_Z;
            info.imm_reg0 = 1'b1;
        end else begin
            info.defined = 1'b0;
        end
        return info;
    endfunction

    // Immediate byte count for a kind; immZ shrinks to 2 under the 66 prefix
    function automatic logic [2:0] imm_bytes(input logic [1:0] kind, input logic o16);
        case (kind)
            IMM_8:   return 3'd1;
            IMM_Z:   return o16 ? 3'd2 : 3'd4;
            IMM_16:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Displacement size implied by ModRM when no SIB follows
    function automatic logic [2:0] modrm_disp(input logic [1:0] md, input logic [2:0] rm);
        case (md)
            2'b00:   return (rm == 3'b101) ? 3'd4 : 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Displacement size once the SIB byte is known
    function automatic logic [2:0] sib_disp(input logic [1:0] md, input logic [2:0] base);
        case (md)
            2'b00:   return (base == 3'b101) ? 3'd4 : 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Registered state
    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [1:0]              lane_q, lane_d;
    logic                    opsize16_q, opsize16_d;
    logic [3:0]              prefix_cnt_q, prefix_cnt_d;
    logic [2:0]              imm_len_q, imm_len_d;
    logic                    imm_reg0_q, imm_reg0_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [1:0]              size_q, size_d;
    logic [1:0]              mod_q, mod_d;
    logic [1:0]              o_instr_size_q, o_instr_size_d;

    // Per-byte decode results
    logic [7:0]              byte_s;
    op_info_t                op_info_s;
    state_e                  nxt_state_s;
    logic                    nxt_opsize_s;
    logic [3:0]              nxt_pcnt_s;
    logic [2:0]              nxt_imm_s;
    logic                    nxt_reg0_s;
    logic [2:0]              nxt_cnt_s;
    logic [1:0]              nxt_size_s;
    logic [1:0]              nxt_mod_s;
    logic                    route_s;
    logic [2:0]              route_disp_s;
    logic [2:0]              route_imm_s;
    logic                    complete_s;
    logic [1:0]              comp_size_s;

    assign byte_s           = buf_q[{lane_q, 3'b000} +: 8];
    assign bus.o_instr_size = o_instr_size_q;

    // Decode the byte in the current lane against the instruction walk state
    always_comb begin
        op_info_s    = classify_op(byte_s);
        nxt_state_s  = state_q;
        nxt_opsize_s = opsize16_q;
        nxt_pcnt_s   = prefix_cnt_q;
        nxt_imm_s    = imm_len_q;
        nxt_reg0_s   = imm_reg0_q;
        nxt_cnt_s    = cnt_q;
        nxt_size_s   = size_q;
        nxt_mod_s    = mod_q;
        route_s      = 1'b0;
        route_disp_s = 3'd0;
        route_imm_s  = 3'd0;
        complete_s   = 1'b0;
        comp_size_s  = SZ_NONE;

        case (state_q)
            ST_PREFIX: begin
                if (is_prefix_byte(byte_s)) begin
                    if (prefix_cnt_q == 4'd14) begin
                        // fifteenth prefix in a row: give up on this instruction
                        complete_s  = 1'b1;
                        comp_size_s = SZ_NONE;
                    end else begin
                        nxt_pcnt_s   = prefix_cnt_q + 4'd1;
                        nxt_opsize_s = (byte_s == 8'h66) ? 1'b1 : opsize16_q;
                    end
                end else if (byte_s == 8'h0F) begin
                    nxt_state_s = ST_OPCODE2;
                end else if (!op_info_s.defined) begin
                    complete_s  = 1'b1;
                    comp_size_s = SZ_NONE;
                end else begin
                    nxt_size_s = is_byte_op(byte_s) ? SZ_BYTE :
                                 (opsize16_q ? SZ_WORD : SZ_DWORD);
                    nxt_imm_s  = imm_bytes(op_info_s.imm, opsize16_q);
                    nxt_reg0_s = op_info_s.imm_reg0;
                    if (op_info_s.modrm) begin
                        nxt_state_s = ST_MODRM;
                    end else begin
                        route_s     = 1'b1;
                        route_imm_s = nxt_imm_s;
                    end
                end
            end
            ST_OPCODE2: begin
                nxt_size_s = opsize16_q ? SZ_WORD : SZ_DWORD;
                nxt_reg0_s = 1'b0;
                if (byte_s[7:4] == 4'h8) begin
                    // Jcc rel32
                    nxt_imm_s   = 3'd4;
                    route_s     = 1'b1;
                    route_imm_s = 3'd4;
                end else begin
                    nxt_imm_s   = 3'd0;
                    nxt_state_s = ST_MODRM;
                end
            end
            ST_MODRM: begin
                nxt_mod_s = byte_s[7:6];
                if (imm_reg0_q && (byte_s[5:3] != 3'b000)) begin
                    nxt_imm_s = 3'd0;
                end else begin
                    nxt_imm_s = imm_len_q;
                end
                if ((byte_s[7:6] != 2'b11) && (byte_s[2:0] == 3'b100)) begin
                    nxt_state_s = ST_SIB;
                end else begin
                    route_s      = 1'b1;
                    route_disp_s = modrm_disp(byte_s[7:6], byte_s[2:0]);
                    route_imm_s  = nxt_imm_s;
                end
            end
            ST_SIB: begin
                route_s      = 1'b1;
                route_disp_s = sib_disp(mod_q, byte_s[2:0]);
                route_imm_s  = imm_len_q;
            end
            ST_DISP: begin
                if (cnt_q == 3'd1) begin
                    route_s     = 1'b1;
                    route_imm_s = imm_len_q;
                end else begin
                    nxt_cnt_s = cnt_q - 3'd1;
                end
            end
            ST_IMM: begin
                if (cnt_q == 3'd1) begin
                    complete_s  = 1'b1;
                    comp_size_s = size_q;
                end else begin
                    nxt_cnt_s = cnt_q - 3'd1;
                end
            end
            default: begin
                nxt_state_s = ST_PREFIX;
            end
        endcase

        // Pick the next trailing field, or finish if none remain
        if (route_s) begin
            if (route_disp_s != 3'd0) begin
                nxt_state_s = ST_DISP;
                nxt_cnt_s   = route_disp_s;
            end else if (route_imm_s != 3'd0) begin
                nxt_state_s = ST_IMM;
                nxt_cnt_s   = route_imm_s;
            end else begin
                complete_s  = 1'b1;
                comp_size_s = nxt_size_s;
            end
        end else begin
            route_disp_s = 3'd0;
        end

        // A finished instruction drops all per-instruction context
        if (complete_s) begin
            nxt_state_s  = ST_PREFIX;
            nxt_opsize_s = 1'b0;
            nxt_pcnt_s   = 4'd0;
            nxt_imm_s    = 3'd0;
            nxt_reg0_s   = 1'b0;
            nxt_cnt_s    = 3'd0;
        end else begin
            comp_size_s = SZ_NONE;
        end
    end

    // Next FSM state: advance only on cycles that consume a byte
    always_comb begin
        if (buf_valid_q) begin
            state_d = nxt_state_s;
        end else begin
            state_d = state_q;
        end
    end

    // Word buffer, lane pointer, instruction context and reported size
    always_comb begin
        buf_d          = buf_q;
        buf_valid_d    = buf_valid_q;
        lane_d         = lane_q;
        opsize16_d     = opsize16_q;
        prefix_cnt_d   = prefix_cnt_q;
        imm_len_d      = imm_len_q;
        imm_reg0_d     = imm_reg0_q;
        cnt_d          = cnt_q;
        size_d         = size_q;
        mod_d          = mod_q;
        o_instr_size_d = o_instr_size_q;
        if (buf_valid_q) begin
            lane_d       = lane_q + 2'd1;
            buf_valid_d  = (lane_q != 2'd3);
            opsize16_d   = nxt_opsize_s;
            prefix_cnt_d = nxt_pcnt_s;
            imm_len_d    = nxt_imm_s;
            imm_reg0_d   = nxt_reg0_s;
            cnt_d        = nxt_cnt_s;
            size_d       = nxt_size_s;
            mod_d        = nxt_mod_s;
            if (complete_s) begin
                o_instr_size_d = comp_size_s;
            end else begin
                o_instr_size_d = o_instr_size_q;
            end
        end else if (bus.i_ready) begin
            buf_d       = bus.i_data;
            buf_valid_d = 1'b1;
            lane_d      = 2'd0;
        end else begin
            buf_d = buf_q;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_PREFIX;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
            lane_q         <= 2'd0;
            opsize16_q     <= 1'b0;
            prefix_cnt_q   <= 4'd0;
            imm_len_q      <= 3'd0;
            imm_reg0_q     <= 1'b0;
            cnt_q          <= 3'd0;
            size_q         <= SZ_NONE;
            mod_q          <= 2'b00;
            o_instr_size_q <= SZ_NONE;
        end else begin
            buf_q          <= buf_d;
            buf_valid_q    <= buf_valid_d;
            lane_q         <= lane_d;
            opsize16_q     <= opsize16_d;
            prefix_cnt_q   <= prefix_cnt_d;
            imm_len_q      <= imm_len_d;
            imm_reg0_q     <= imm_reg0_d;
            cnt_q          <= cnt_d;
            size_q         <= size_d;
            mod_q          <= mod_d;
            o_instr_size_q <= o_instr_size_d;
        end
    end

endmodule

// File: tb/tb_x86_stream_length_decoder.sv
// Self-checking bench for x86_stream_length_decoder: directed scenarios with
// literal expectations plus random byte streams checked against an
// instruction-level reference parser over a queue of consumed bytes.
module tb_x86_stream_length_decoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    x86_stream_length_decoder_if bus();

    x86_stream_length_decoder #(.DATA_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: bytes of the instruction in progress
    logic [7:0] byte_q[$];
    logic [1:0] exp_size;
    logic [1:0] obs  [4];
    logic [1:0] expv [4];

    logic [7:0] pool [16] = '{8'h66, 8'h0F, 8'h90, 8'hB8, 8'h81, 8'hF7, 8'hF6, 8'h8B,
                              8'h04, 8'h44, 8'h84, 8'hC2, 8'h6A, 8'h05, 8'hFF, 8'h83};

    function automatic bit ref_is_pfx(input logic [7:0] b);
        return b inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
                         8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    endfunction

    function automatic bit ref_byte_size(input logic [7:0] op);
        return op inside {8'h00, 8'h02, 8'h04, 8'h08, 8'h0A, 8'h0C, 8'h10, 8'h12, 8'h14,
                          8'h18, 8'h1A, 8'h1C, 8'h20, 8'h22, 8'h24, 8'h28, 8'h2A, 8'h2C,
                          8'h30, 8'h32, 8'h34, 8'h38, 8'h3A, 8'h3C, 8'h80, 8'h84, 8'h86,
                          8'h88, 8'h8A, [8'hB0:8'hB7], 8'hC0, 8'hC6, 8'hD0, 8'hD2,
                          8'hF6, 8'hFE};
    endfunction

    // Opcode table: defined?, ModRM?, immediate bytes, immediate only if reg==0
    function automatic void ref_op(input logic [7:0] op, input bit o16, output bit defd,
                                   output bit hm, output int imm, output bit r0);
        int z;
        z = o16 ? 2 : 4;
        defd = 1; hm = 0; imm = 0; r0 = 0;
        if (op < 8'h40) begin
            if (op % 8 < 4) hm = 1;
            else if (op % 8 == 4) imm = 1;
            else if (op % 8 == 5) imm = z;
        end
        else if (op inside {[8'h40:8'h5F], [8'h90:8'h9F], 8'hC3, 8'hC9, 8'hCC, 8'hF4}) imm = 0;
        else if (op inside {8'h68, [8'hB8:8'hBF], 8'hE8, 8'hE9}) imm = z;
        else if (op inside {8'h6A, [8'h70:8'h7F], [8'hB0:8'hB7], 8'hEB}) imm = 1;
        else if (op == 8'hC2) imm = 2;
        else if (op inside {8'h69, 8'h81, 8'hC7}) begin hm = 1; imm = z; end
        else if (op inside {8'h6B, 8'h80, 8'h83, 8'hC0, 8'hC1, 8'hC6}) begin hm = 1; imm = 1; end
        else if (op inside {[8'h84:8'h8F], [8'hD0:8'hD3], 8'hFE, 8'hFF}) hm = 1;
        else if (op == 8'hF6) begin hm = 1; imm = 1; r0 = 1; end
        else if (op == 8'hF7) begin hm = 1; imm = z; r0 = 1; end
        else defd = 0;
    endfunction

    // Parse byte_q from its start; len = total length once all bytes are present, else 0
    function automatic void model_decode(output int len, output logic [1:0] sz);
        int n, p, npre, imm, disp;
        bit o16, defd, hm, r0;
        logic [7:0] op;
        logic [1:0] md;
        logic [2:0] rg, rm;
        n = byte_q.size(); p = 0; npre = 0; o16 = 0; disp = 0;
        len = 0; sz = 2'b11;
        while (p < n && ref_is_pfx(byte_q[p])) begin
            if (byte_q[p] == 8'h66) o16 = 1;
            p++; npre++;
            if (npre == 15) begin len = p; sz = 2'b11; return; end
        end
        if (p >= n) return;
        op = byte_q[p]; p++;
        if (op == 8'h0F) begin
            if (p >= n) return;
            hm = (byte_q[p][7:4] != 4'h8);
            imm = hm ? 0 : 4; r0 = 0; p++;
            sz = o16 ? 2'b01 : 2'b10;
        end else begin
            ref_op(op, o16, defd, hm, imm, r0);
            if (!defd) begin len = p; sz = 2'b11; return; end
            sz = ref_byte_size(op) ? 2'b00 : (o16 ? 2'b01 : 2'b10);
        end
        if (hm) begin
            if (p >= n) return;
            md = byte_q[p][7:6]; rg = byte_q[p][5:3]; rm = byte_q[p][2:0]; p++;
            if (r0 && rg != 3'd0) imm = 0;
            if (md != 2'b11 && rm == 3'b100) begin
                if (p >= n) return;
                if (md == 2'b00 && byte_q[p][2:0] == 3'b101) disp = 4;
                p++;
            end else if (md == 2'b00 && rm == 3'b101) disp = 4;
            if (md == 2'b01) disp = 1;
            else if (md == 2'b10) disp = 4;
        end
        if (p + disp + imm <= n) len = p + disp + imm;
    endfunction

    function automatic void model_step(input logic [7:0] b);
        int len;
        logic [1:0] sz;
        byte_q.push_back(b);
        model_decode(len, sz);
        if (len > 0) begin
            exp_size = sz;
            for (int k = 0; k < len; k++) void'(byte_q.pop_front());
        end
    endfunction

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 15)];
        else return 8'($urandom);
    endfunction

    // Hold reset for two edges; returns at a falling edge with reset released
    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_data = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        byte_q.delete();
        exp_size = 2'b11;
    endtask

    // Deliver one word (called at a falling edge, buffer empty); record output per lane
    task automatic push_word(input logic [31:0] w, input bit keep);
        bus.i_ready = 1'b1;
        bus.i_data = w;
        @(negedge clk);
        if (!keep) bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            model_step(w[i*8 +: 8]);
            obs[i] = bus.o_instr_size;
            expv[i] = exp_size;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.o_instr_size !== 2'b11) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %b want 11", i, bus.o_instr_size);
            end
        end
    endtask

    task automatic test_nops();
        logic [1:0] want [4] = '{2'b10, 2'b10, 2'b10, 2'b10};
        do_reset();
        push_word(32'h90909090, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== want[i]) begin
                n_err++;
                $display("FAIL nops lane%0d: got %b want %b", i, obs[i], want[i]);
            end
        end
    endtask

    task automatic test_byte_ops();
        logic [1:0] want [4] = '{2'b11, 2'b00, 2'b00, 2'b00};
        do_reset();
        push_word(32'h000005B0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== want[i]) begin
                n_err++;
                $display("FAIL byte_ops lane%0d: got %b want %b", i, obs[i], want[i]);
            end
        end
    endtask

    task automatic test_opsize16();
        logic [1:0] want [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
        do_reset();
        push_word(32'h1234B866, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== want[i]) begin
                n_err++;
                $display("FAIL opsize16 lane%0d: got %b want %b", i, obs[i], want[i]);
            end
        end
    endtask

    task automatic test_cross_word();
        logic [1:0] want [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [1:0] got  [8];
        do_reset();
        push_word(32'h345678B8, 1'b0);
        for (int i = 0; i < 4; i++) got[i] = obs[i];
        push_word(32'h90909012, 1'b0);
        for (int i = 0; i < 4; i++) got[i+4] = obs[i];
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (got[i] !== want[i]) begin
                n_err++;
                $display("FAIL cross_word byte%0d: got %b want %b", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        bus.i_data = 32'h04458B90;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.o_instr_size !== 2'b10) begin
            n_err++;
            $display("FAIL midreset_pre: got %b want 10", bus.o_instr_size);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        byte_q.delete();
        exp_size = 2'b11;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.o_instr_size !== 2'b11) begin
                n_err++;
                $display("FAIL midreset_flush cycle %0d: got %b want 11", i, bus.o_instr_size);
            end
            @(negedge clk);
        end
        push_word(32'h90909090, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== 2'b10) begin
                n_err++;
                $display("FAIL midreset_after lane%0d: got %b want 10", i, obs[i]);
            end
        end
    endtask

    task automatic test_prefix_limit();
        logic [1:0] got [8];
        // 1 nop, then exactly 15 prefixes: the fifteenth forces size 11
        do_reset();
        push_word(32'h66666690, 1'b0);
        got[0] = obs[0];
        push_word(32'h66666666, 1'b0);
        push_word(32'h66666666, 1'b0);
        push_word(32'h66666666, 1'b0);
        got[1] = obs[2];
        got[2] = obs[3];
        push_word(32'h90909090, 1'b0);
        got[3] = obs[0];
        // 14 prefixes then a nop is still a normal 16-bit instruction
        do_reset();
        push_word(32'h66666666, 1'b0);
        push_word(32'h66666666, 1'b0);
        push_word(32'h66666666, 1'b0);
        push_word(32'h90906666, 1'b0);
        got[4] = obs[1];
        got[5] = obs[2];
        got[6] = obs[3];
        got[7] = got[6];
        if (got[0] !== 2'b10) begin n_err++; $display("FAIL plimit_nop: got %b want 10", got[0]); end
        if (got[1] !== 2'b10) begin n_err++; $display("FAIL plimit_14th: got %b want 10", got[1]); end
        if (got[2] !== 2'b11) begin n_err++; $display("FAIL plimit_15th: got %b want 11", got[2]); end
        if (got[3] !== 2'b10) begin n_err++; $display("FAIL plimit_after: got %b want 10", got[3]); end
        if (got[4] !== 2'b11) begin n_err++; $display("FAIL p14_pending: got %b want 11", got[4]); end
        if (got[5] !== 2'b01) begin n_err++; $display("FAIL p14_nop16: got %b want 01", got[5]); end
        if (got[6] !== 2'b10) begin n_err++; $display("FAIL p14_nop32: got %b want 10", got[6]); end
        n_vec += 7;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int w = 0; w < 40; w++) begin
            push_word({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 1'b1);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs[i] !== expv[i]) begin
                    n_err++;
                    $display("FAIL b2b word%0d lane%0d: got %b want %b", w, i, obs[i], expv[i]);
                end
            end
        end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int w = 0; w < 400; w++) begin
            push_word({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 1'($urandom_range(0, 1)));
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs[i] !== expv[i]) begin
                    n_err++;
                    $display("FAIL random word%0d lane%0d: got %b want %b", w, i, obs[i], expv[i]);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.i_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                n_vec++;
                if (bus.o_instr_size !== exp_size) begin
                    n_err++;
                    $display("FAIL random_idle word%0d: got %b want %b", w, bus.o_instr_size, exp_size);
                end
            end
        end
        bus.i_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_data = 32'h0;
        exp_size = 2'b11;
        test_reset();
        test_nops();
        test_byte_ops();
        test_opsize16();
        test_cross_word();
        test_reset_mid_word();
        test_prefix_limit();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
